// File: rtl/tt_um_arraydivider_if.sv
// rtl/tt_um_arraydivider_if.sv - divider request/result bundle
// Purpose: groups the divider operand request and result signals.
// Signals: start/dividend/divisor (requester -> divider),
//          busy/done/quotient/remainder/div_zero (divider -> requester).
// Modports: master = requester side, slave = divider side.
interface tt_um_arraydivider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/tt_um_arraydivider.sv
// rtl/tt_um_arraydivider.sv - sequential restoring divider, one quotient bit per clock
// Purpose: unsigned WIDTH-bit divide; quotient/remainder registered with a one-cycle done pulse.
// Ports: clk       - clock, all state on rising edge
//        rst       - synchronous active-high reset
//        bus       - tt_um_arraydivider_if slave (start/operands in, busy/done/results out)
module tt_um_arraydivider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    tt_um_arraydivider_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    // Partial remainder is always below the divisor between iterations, so
    // WIDTH bits hold it; the extra bit only exists in the shifted/subtracted value.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    count_q, count_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        count_d     = count_q;
        dz_d        = dz_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        r_shift = {r_q, q_q[WIDTH-1]};
        diff    = r_shift - {1'b0, d_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d     = bus.dividend;
                    d_d     = bus.divisor;
                    r_d     = '0;
                    count_d = '0;
                    dz_d    = (bus.divisor == '0);
                    state_d = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // diff[WIDTH] is the borrow: set exactly when r_shift < divisor.
                if (!diff[WIDTH]) begin
                    r_d = diff[WIDTH-1:0];
                end else begin
                    r_d = r_shift[WIDTH-1:0];
                end
                q_d     = {q_q[WIDTH-2:0], ~diff[WIDTH]};
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                if (dz_q) begin
                    // Q still holds the untouched dividend on the divide-by-zero path.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    div_zero_d  = 1'b1;
                end else begin
                    quotient_d  = q_q;
                    remainder_d = r_q;
                    div_zero_d  = 1'b0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            count_q     <= '0;
            dz_q        <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            count_q     <= count_d;
            dz_q        <= dz_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: tb/tb_tt_um_arraydivider.sv
// tb/tb_tt_um_arraydivider.sv - directed self-checking bench for tt_um_arraydivider
module tb_tt_um_arraydivider;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    tt_um_arraydivider_if #(.WIDTH(8)) bus ();

    tt_um_arraydivider #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cyc, output bit got);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_cyc  = bus.busy ? 1 : 0;
        lat       = 0;
        got       = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd2;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        n_checks++; if (bus.quotient !== 8'd0) begin n_fail++; $display("FAIL reset_quotient: got %0d expected 0", bus.quotient); end
        n_checks++; if (bus.remainder !== 8'd0) begin n_fail++; $display("FAIL reset_remainder: got %0d expected 0", bus.remainder); end
        n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %0b expected 0", bus.div_zero); end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat, busy_cyc;
        bit got;
        run_op(8'd200, 8'd7, lat, busy_cyc, got);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL basic_done_seen: got %0b expected 1", got); end
        n_checks++; if (lat != 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", lat); end
        n_checks++; if (busy_cyc != 9) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 9", busy_cyc); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %0b expected 0", bus.busy); end
        n_checks++; if (bus.quotient !== 8'd28) begin n_fail++; $display("FAIL basic_quotient: got %0d expected 28", bus.quotient); end
        n_checks++; if (bus.remainder !== 8'd4) begin n_fail++; $display("FAIL basic_remainder: got %0d expected 4", bus.remainder); end
        n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL basic_div_zero: got %0b expected 0", bus.div_zero); end
        @(posedge clk);
        #1;
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b expected 0", bus.done); end
        n_checks++; if (bus.quotient !== 8'd28) begin n_fail++; $display("FAIL basic_quotient_held: got %0d expected 28", bus.quotient); end
    endtask

    task automatic test_corners();
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic [7:0] eq [4];
        logic [7:0] er [4];
        int lat, busy_cyc;
        bit got;
        ta = '{8'd255, 8'd5, 8'd255, 8'd0};
        tb = '{8'd1,   8'd9, 8'd255, 8'd3};
        eq = '{8'd255, 8'd0, 8'd1,   8'd0};
        er = '{8'd0,   8'd5, 8'd0,   8'd0};
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], lat, busy_cyc, got);
            n_checks++; if (!got || lat != 9) begin n_fail++; $display("FAIL corner%0d_latency: got %0d (done %0b) expected 9", k, lat, got); end
            n_checks++; if (bus.quotient !== eq[k]) begin n_fail++; $display("FAIL corner%0d_quotient: got %0d expected %0d", k, bus.quotient, eq[k]); end
            n_checks++; if (bus.remainder !== er[k]) begin n_fail++; $display("FAIL corner%0d_remainder: got %0d expected %0d", k, bus.remainder, er[k]); end
        end
    endtask

    task automatic test_div_zero();
        int lat, busy_cyc;
        bit got;
        run_op(8'd77, 8'd0, lat, busy_cyc, got);
        n_checks++; if (!got || lat != 1) begin n_fail++; $display("FAIL dz_latency: got %0d (done %0b) expected 1 edge after start edge", lat, got); end
        n_checks++; if (bus.quotient !== 8'hFF) begin n_fail++; $display("FAIL dz_quotient: got %0h expected ff", bus.quotient); end
        n_checks++; if (bus.remainder !== 8'd77) begin n_fail++; $display("FAIL dz_remainder: got %0d expected 77", bus.remainder); end
        n_checks++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %0b expected 1", bus.div_zero); end
        run_op(8'd10, 8'd3, lat, busy_cyc, got);
        n_checks++; if (!got || lat != 9) begin n_fail++; $display("FAIL dz_next_latency: got %0d (done %0b) expected 9", lat, got); end
        n_checks++; if (bus.quotient !== 8'd3) begin n_fail++; $display("FAIL dz_next_quotient: got %0d expected 3", bus.quotient); end
        n_checks++; if (bus.remainder !== 8'd1) begin n_fail++; $display("FAIL dz_next_remainder: got %0d expected 1", bus.remainder); end
        n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_next_flag: got %0b expected 0", bus.div_zero); end
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                bus.start    = 1'b1;
                bus.dividend = 8'd50;
                bus.divisor  = 8'd5;
            end
            if (e == 4) bus.start = 1'b0;
            if (e == 8) begin
                n_checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL ign_pre_done: got busy %0b done %0b expected busy 1 done 0", bus.busy, bus.done); end
                bus.start = 1'b1;
            end
            if (e == 9) begin
                n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ign_done: got %0b expected 1", bus.done); end
                n_checks++; if (bus.quotient !== 8'd28 || bus.remainder !== 8'd4) begin n_fail++; $display("FAIL ign_first_result: got %0d r%0d expected 28 r4", bus.quotient, bus.remainder); end
            end
            if (e == 10) begin
                bus.start = 1'b0;
                n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ign_accept_after_done: got busy %0b expected 1", bus.busy); end
            end
            if (e == 19) begin
                n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ign_second_done: got %0b expected 1", bus.done); end
                n_checks++; if (bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin n_fail++; $display("FAIL ign_second_result: got %0d r%0d expected 10 r0", bus.quotient, bus.remainder); end
            end
        end
    endtask

    task automatic test_reset_midrun();
        int lat, busy_cyc;
        bit got;
        bit saw_done;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd200;
        bus.divisor  = 8'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: got busy %0b done %0b expected 0 0", bus.busy, bus.done); end
        n_checks++; if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0 || bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got q %0d r %0d dz %0b expected 0 0 0", bus.quotient, bus.remainder, bus.div_zero); end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done: got %0b expected 0", saw_done); end
        run_op(8'd100, 8'd10, lat, busy_cyc, got);
        n_checks++; if (!got || lat != 9) begin n_fail++; $display("FAIL midrst_next_latency: got %0d (done %0b) expected 9", lat, got); end
        n_checks++; if (bus.quotient !== 8'd10 || bus.remainder !== 8'd0) begin n_fail++; $display("FAIL midrst_next_result: got %0d r%0d expected 10 r0", bus.quotient, bus.remainder); end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_ignore_start();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
